// File: rtl/cache_refill_engine_pkg.sv
// Shared types and geometry for the cache refill engine.
package cache_refill_engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WORDS_PER_BLOCK  = 4;
  localparam int BLOCK_WIDTH      = 128;
  localparam int WORD_OFFSET_BITS = 2;
  localparam int BYTE_OFFSET_BITS = 2;

endpackage

// File: rtl/cache_refill_engine.sv
// Main-memory side of the cache: 4-beat block refill on a read miss and
// single-beat write-through stores. Holds the pipeline in stall while busy.
//
// Handshake: a memory beat is transferred on every rising edge where
// mem_req & mem_ready are both high. mem_req/mem_we/mem_addr/mem_wdata are
// decoded from registered state only and stay stable until that edge.
module cache_refill_engine
  import cache_refill_engine_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_BLOCK = cache_refill_engine_pkg::WORDS_PER_BLOCK
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_read,
  input  logic                                req_write,
  input  logic [ADDR_WIDTH-1:0]               req_addr,
  input  logic [WORD_WIDTH-1:0]               req_wdata,
  output logic                                stall,
  output logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] block_from_mem,
  output logic                                block_valid,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [WORD_WIDTH-1:0]               mem_wdata,
  input  logic                                mem_ready,
  input  logic [WORD_WIDTH-1:0]               mem_rdata,
  output logic [1:0]                          dbg_state
);

  localparam int OFFSET_BITS = WORD_OFFSET_BITS + BYTE_OFFSET_BITS;
  localparam logic [WORD_OFFSET_BITS-1:0] LAST_BEAT = WORD_OFFSET_BITS'(WORDS_PER_BLOCK - 1);

  state_t                              state_q, state_d;
  logic [WORD_OFFSET_BITS-1:0]         beat_q;
  logic [ADDR_WIDTH-1:OFFSET_BITS]     base_q;
  logic [ADDR_WIDTH-1:0]               waddr_q;
  logic [WORD_WIDTH-1:0]               wdata_q;
  logic [WORDS_PER_BLOCK*WORD_WIDTH-1:0] block_q;
  logic                                from_read_q;

  assign block_from_mem = block_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    block_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous read and write is illegal upstream; the read wins.
        if (req_read) begin
          stall   = 1'b1;
          state_d = READ;
        end else if (req_write) begin
          stall   = 1'b1;
          state_d = WRITE;
        end
      end
      READ: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {base_q, beat_q, {BYTE_OFFSET_BITS{1'b0}}};
        if (mem_ready && beat_q == LAST_BEAT) state_d = DONE;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = wdata_q;
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        // Requests are ignored here: the miss signal lags the cache update.
        block_valid = from_read_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      base_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      block_q     <= '0;
      from_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_read) begin
            base_q      <= req_addr[ADDR_WIDTH-1:OFFSET_BITS];
            beat_q      <= '0;
            from_read_q <= 1'b1;
          end else if (req_write) begin
            waddr_q     <= req_addr;
            wdata_q     <= req_wdata;
            from_read_q <= 1'b0;
          end
        end
        READ: begin
          if (mem_ready) begin
            block_q[int'(beat_q)*WORD_WIDTH +: WORD_WIDTH] <= mem_rdata;
            beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Self-checking bench for cache_refill_engine: constant vector table,
// hand-written reset sequences and randomized traffic against a transaction model.
module tb_cache_refill_engine;
  import cache_refill_engine_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_read = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         stall;
  logic [127:0] block_from_mem;
  logic         block_valid;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  cache_refill_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .block_from_mem (block_from_mem),
    .block_valid    (block_valid),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];   // {we, addr, wdata-or-0} per expected memory beat
  int          wait_q[$];  // wait states the memory inserts before each beat
  int          cur_wait = -1;
  logic [31:0] key = '0;   // memory contents are addr ^ key

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    int          exp_stall;
    int          exp_bv;
    int          exp_we;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_mem();
    mem_rdata = rdfn(mem_addr);
    if (!mem_req) begin
      mem_ready = 1'b0;
    end else begin
      if (cur_wait < 0) cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
      mem_ready = (cur_wait == 0);
      if (mem_ready) cur_wait = -1;
      else cur_wait--;
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle. wt < 0 picks random waits.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int wt,
                         output int stall_cnt, output int bv_cnt, output int we_cnt);
    logic [31:0]  base;
    logic [127:0] exp_blk;
    logic [64:0]  obs;
    logic [31:0]  prev_addr;
    logic         prev_wait;
    int           exp_stall;
    int           w;
    int           tail;
    bit           seen;
    base      = {addr[31:4], 4'b0};
    exp_blk   = '0;
    exp_stall = 1;
    stall_cnt = 0;
    bv_cnt    = 0;
    we_cnt    = 0;
    if (rd) begin
      for (int i = 0; i < 4; i++) begin
        w = (wt < 0) ? int'($urandom_range(0, 3)) : wt;
        wait_q.push_back(w);
        exp_stall += 1 + w;
        exp_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
        exp_blk[32*i +: 32] = rdfn(base + 32'(4 * i));
      end
    end else if (wr) begin
      w = (wt < 0) ? int'($urandom_range(0, 3)) : wt;
      wait_q.push_back(w);
      exp_stall += 1 + w;
      exp_q.push_back({1'b1, addr, wdata});
    end
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tail      = -1;
    seen      = 1'b0;
    prev_wait = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 300 && tail < 3; c++) begin
      if (tail >= 1) begin
        req_read  = 1'b0;
        req_write = 1'b0;
      end
      drive_mem();
      #1;
      if (stall) begin
        stall_cnt++;
        seen = 1'b1;
      end else if (seen && tail < 0) begin
        tail = 0;
      end
      if (block_valid) begin
        bv_cnt++;
        check("block_at_valid", block_from_mem, exp_blk);
      end
      if (prev_wait) check("addr_hold_in_wait", {95'h0, mem_req, mem_addr}, {95'h0, 1'b1, prev_addr});
      if (mem_req && mem_ready) begin
        obs = {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0};
        if (mem_we) we_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", obs);
        end else begin
          check("mem_beat", 128'(obs), 128'(exp_q.pop_front()));
        end
      end
      prev_wait = mem_req && !mem_ready;
      prev_addr = mem_addr;
      if (tail >= 0) tail++;
      @(posedge clk);
      #1;
    end
    if (tail < 3) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: got stall_cycles %0d expected completion", stall_cnt);
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    mem_ready = 1'b0;
    check("stall_cycles", 128'(stall_cnt), 128'(exp_stall));
    check("block_valid_count", 128'(bv_cnt), rd ? 128'd1 : 128'd0);
    check("write_beats", 128'(we_cnt), (!rd && wr) ? 128'd1 : 128'd0);
    check("beats_outstanding", 128'(exp_q.size()), 128'd0);
    if (rd) check("block_hold", block_from_mem, exp_blk);
    exp_q.delete();
    wait_q.delete();
    cur_wait = -1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s, b, we, beats, kind;
    logic [31:0] a;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1238, 32'h0,         0,  5, 1, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1238, 32'h0,         2, 13, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0,  2, 0, 1};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 1,  3, 0, 1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 0,  5, 1, 0};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1,  9, 1, 0};

    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_req", 128'(mem_req), 128'd0);
    check("reset_mem_we", 128'(mem_we), 128'd0);
    check("reset_stall", 128'(stall), 128'd0);
    check("reset_block_valid", 128'(block_valid), 128'd0);
    check("reset_block", block_from_mem, 128'd0);
    check("reset_mem_addr_wdata", {64'h0, mem_addr, mem_wdata}, 128'd0);
    check("reset_state", 128'(dbg_state), 128'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant vector table
    key = '0;
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt, s, b, we);
      check("vec_stall", 128'(s), 128'(vecs[i].exp_stall));
      check("vec_block_valid", 128'(b), 128'(vecs[i].exp_bv));
      check("vec_write_beats", 128'(we), 128'(vecs[i].exp_we));
      if (i < 2) check("vec_block_1230", block_from_mem, 128'h0000123C_00001238_00001234_00001230);
    end

    // Reset after beat 1 of a refill
    req_read = 1'b1;
    req_addr = 32'h0000_3008;
    beats    = 0;
    for (int c = 0; c < 50 && beats < 2; c++) begin
      mem_ready = mem_req;
      mem_rdata = rdfn(mem_addr);
      #1;
      if (mem_req && mem_ready) beats++;
      @(posedge clk);
      #1;
    end
    check("pre_reset_mem_req", 128'(mem_req), 128'd1);
    rst_n     = 1'b0;
    req_read  = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_mem_req", 128'(mem_req), 128'd0);
    check("midreset_block_valid", 128'(block_valid), 128'd0);
    check("midreset_block_cleared", block_from_mem, 128'd0);
    check("midreset_stall", 128'(stall), 128'd0);
    check("midreset_state", 128'(dbg_state), 128'(IDLE));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    b = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (block_valid || mem_req) b++;
      @(posedge clk);
      #1;
    end
    check("post_reset_quiet", 128'(b), 128'd0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, 32'h0, 0, s, b, we);

    // Randomized traffic against the transaction model
    for (int i = 0; i < 30; i++) begin
      key  = $urandom;
      kind = int'($urandom_range(0, 5));
      a    = $urandom & 32'hFFFF_FFFC;
      run_txn(kind < 3, kind >= 2, a, $urandom, -1, s, b, we);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
